hdmi_i2c_read_rdata: RTL and testbench
======================================

# hdmi_i2c_read_rdata

Bit-banged I2C read master for the HDMI transmitter configuration path, the read-direction counterpart of the HDMI I2C register writer. One register-read transaction per GO handshake: write slave address, write register address, repeated START, read slave address, then one or two data bytes, then STOP. Each bus phase advances on one PT_CK tick, so PT_CK sets the SCL rate. Shares the SDAO/SCLO/SDAI bus wiring with the writer through the existing open-drain muxing.

## Interface
- No parameters.
- PT_CK  in  1  phase tick clock; all logic on rising edge
- RESET  in  1  synchronous reset, active-high
- GO  in  1  transaction request; high arms, falling level launches
- SLAVE_ADDRESS  in  8  7-bit address in [7:1]; [0] ignored, R/W bit forced internally
- REG_ADDR  in  8  register address to read
- BYTE_NUM  in  2  bytes to read; 0 treated as 1, 3 treated as 2
- SDAI  in  1  SDA line sampled from pad
- SDAO  out  1  SDA drive (1 = release)
- SCLO  out  1  SCL drive (1 = release)
- END_OK  out  1  high when idle or finished; low during transaction
- ACK_ERR  out  1  sticky for the transaction: a slave NACK occurred
- RDATA  out  16  read data; byte 1 in [15:8], byte 2 in [7:0]
- RDATA_VALID  out  1  one-tick pulse, data good
- ST  out  8  current state, debug only

## Operation
- States: IDLE, ARM, S1, S2, BSET, BHI, BLO, RS1, RS2, RS3, P1, P2, P3, DONE.
- IDLE: SDAO=1, SCLO=1, END_OK=1. GO=1 -> ARM.
- ARM: waits GO=0. On that edge, captures SLAVE_ADDRESS, REG_ADDR, clamped BYTE_NUM into shadow regs. Also clears ACK_ERR, drives END_OK=0, and moves to S1.
- START: S1 drives {SDAO,SCLO}=01, S2 drives 00.
- Frame: 9 bits, MSB first, 3 ticks per bit.
  - BSET: SCLO=0, SDAO=bit.
  - BHI: SCLO=1.
  - BLO: SCLO=0, registers SDAI.
- Frame sequence:
  - F1: {SLAVE_ADDRESS[7:1],0} plus released ack bit.
  - F2: REG_ADDR plus released ack bit.
  - Repeated START: RS1 {1,0}, RS2 {1,1}, RS3 {0,1}.
  - F3: {SLAVE_ADDRESS[7:1],1} plus released ack bit.
  - F4..: data frames. SDAO=1 for 8 bits, SDAI sampled in BLO shifts in MSB first. Ninth bit is master ACK (SDAO=0) if another byte follows, otherwise NACK (SDAO=1).
- After F1 to F3, the ninth-bit sample decides the next step:
  - Sample 1: sets ACK_ERR=1 and goes directly to P1.
  - Sample 0: continues.
- STOP: P1 {0,0}, P2 {0,1}, P3 {1,1}, then DONE.
- DONE: END_OK=1. RDATA_VALID=1 for this tick only when ACK_ERR=0. Then goes to IDLE.
- RDATA loading:
  - Updates only when the transaction completes without error.
  - For one byte, RDATA={8'h00, byte}.
  - For two bytes, RDATA={byte1, byte2}.
  - RDATA holds between transactions.
- GO held high across DONE: the block passes through IDLE to ARM and waits for GO=0 again. One transaction per GO falling.
- Input changes after ARM launch have no effect on the transaction in progress.
- No clock stretching: SCLO is never read back.

## Timing
- Reset values: SDAO=1, SCLO=1, END_OK=1, ACK_ERR=0, RDATA=16'h0000, RDATA_VALID=0, ST=IDLE.
- RESET mid-transaction: the next edge forces the reset values. SDA and SCL are released without a STOP. RDATA_VALID is not pulsed.
- Ticks from entering S1 to entering DONE = 2 + 27*(3+N) + 3 + 3, where N is the clamped BYTE_NUM.
  - N=1: 116 ticks.
  - N=2: 143 ticks.
- END_OK falls on the ARM->S1 edge. It rises on the edge entering DONE.
- Abort on NACK at frame k (1..3): ticks from S1 to DONE = 2 + 27*k + 3*(k==3) + 3.
- SDA changes only while SCLO=0, except in S1, RS2->RS3 and P2->P3.
- SDAI is registered on the BHI->BLO edge, i.e. the value present while SCL is high.

## Test plan
- Slave model at 0x39 (SLAVE_ADDRESS=0x72) acks all, returns 0xA5. REG_ADDR=0x41, BYTE_NUM=1, GO pulse.
  - Bus shows 0x72 ack, 0x41 ack, Sr, 0x73 ack, 0xA5, master NACK, STOP.
  - RDATA=0x00A5 and RDATA_VALID pulses once.
  - END_OK is low for exactly 116 ticks.
- BYTE_NUM=2, slave returns 0x12 then 0x34.
  - Master ACK after the first byte, NACK after the second.
  - RDATA=0x1234 and END_OK is low for 143 ticks.
- Slave NACKs F1.
  - ACK_ERR=1 and STOP follows immediately.
  - No RDATA_VALID, RDATA unchanged.
  - END_OK is low for 32 ticks.
- Slave NACKs F3.
  - ACK_ERR=1, abort after F3, END_OK is low for 89 ticks.
  - A following good transaction clears ACK_ERR at launch.
- BYTE_NUM=0 behaves as 1; BYTE_NUM=3 behaves as 2.
  - SLAVE_ADDRESS[0]=1 input still produces 0x72 then 0x73 on the bus.
- RESET asserted mid-F4.
  - Next edge: SDAO=1, SCLO=1, END_OK=1, ST=IDLE, no RDATA_VALID.
  - GO held high through DONE triggers no second transaction until GO toggles low.

Source files
------------

// File: rtl/hdmi_i2c_read_rdata.sv
// Bit-banged I2C register-read master for the HDMI transmitter config path.
// One transaction per GO falling level: addr+W, reg, Sr, addr+R, 1-2 data bytes, STOP.
module hdmi_i2c_read_rdata (
    input  logic        PT_CK,
    input  logic        RESET,
    input  logic        GO,
    input  logic [7:0]  SLAVE_ADDRESS,
    input  logic [7:0]  REG_ADDR,
    input  logic [1:0]  BYTE_NUM,
    input  logic        SDAI,
    output logic        SDAO,
    output logic        SCLO,
    output logic        END_OK,
    output logic        ACK_ERR,
    output logic [15:0] RDATA,
    output logic        RDATA_VALID,
    output logic [7:0]  ST
);

    typedef enum logic [3:0] {
        IDLE, ARM, S1, S2, BSET, BHI, BLO, RS1, RS2, RS3, P1, P2, P3, DONE
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  frame_q, frame_d;     // 0:F1 1:F2 2:F3 3,4:data bytes
    logic [3:0]  bit_q, bit_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  reg_q, reg_d;
    logic        two_q, two_d;
    logic        sda_q, sda_d;
    logic [15:0] rx_q, rx_d;
    logic        ack_err_q, ack_err_d;
    logic [15:0] rdata_q, rdata_d;

    logic [7:0]  tx_byte;
    logic        tx_bit;
    logic        last_bit;
    logic        data_frame;

    // Address LSB is replaced by the R/W bit, and BYTE_NUM clamps to its MSB.
    logic unused_inputs;
    assign unused_inputs = ^{SLAVE_ADDRESS[0], BYTE_NUM[0]};

    assign last_bit   = (bit_q == 4'd8);
    assign data_frame = (frame_q >= 3'd3);

    always_comb begin
        tx_byte = 8'hFF;
        case (frame_q)
            3'd0:    tx_byte = {addr_q, 1'b0};
            3'd1:    tx_byte = reg_q;
            3'd2:    tx_byte = {addr_q, 1'b1};
            default: tx_byte = 8'hFF;
        endcase
    end

    // Ninth bit: released for slave ack, master ACK only before a second data byte.
    assign tx_bit = last_bit ? !((frame_q == 3'd3) && two_q) : tx_byte[~bit_q[2:0]];

    always_ff @(posedge PT_CK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (GO)  state_d = ARM;
            ARM:  if (!GO) state_d = S1;
            S1:   state_d = S2;
            S2:   state_d = BSET;
            BSET: state_d = BHI;
            BHI:  state_d = BLO;
            BLO: begin
                if (!last_bit)                 state_d = BSET;
                else if (!data_frame && sda_q) state_d = P1;
                else begin
                    case (frame_q)
                        3'd0:    state_d = BSET;
                        3'd1:    state_d = RS1;
                        3'd2:    state_d = BSET;
                        3'd3:    state_d = two_q ? BSET : P1;
                        default: state_d = P1;
                    endcase
                end
            end
            RS1:  state_d = RS2;
            RS2:  state_d = RS3;
            RS3:  state_d = BSET;
            P1:   state_d = P2;
            P2:   state_d = P3;
            P3:   state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_d   = frame_q;
        bit_d     = bit_q;
        addr_d    = addr_q;
        reg_d     = reg_q;
        two_d     = two_q;
        sda_d     = sda_q;
        rx_d      = rx_q;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;
        case (state_q)
            ARM: if (!GO) begin
                addr_d    = SLAVE_ADDRESS[7:1];
                reg_d     = REG_ADDR;
                two_d     = BYTE_NUM[1];
                ack_err_d = 1'b0;
                rx_d      = '0;
                frame_d   = '0;
                bit_d     = '0;
            end
            BHI: begin
                sda_d = SDAI;
                if (data_frame && !last_bit) rx_d = {rx_q[14:0], SDAI};
            end
            BLO: begin
                if (!last_bit) bit_d = bit_q + 4'd1;
                else begin
                    bit_d   = '0;
                    frame_d = frame_q + 3'd1;
                    if (!data_frame && sda_q) ack_err_d = 1'b1;
                end
            end
            // rx_q starts at zero, so a single byte lands as {8'h00, byte}
            P3: if (!ack_err_q) rdata_d = rx_q;
            default: ;
        endcase
    end

    always_ff @(posedge PT_CK) begin
        if (RESET) begin
            frame_q   <= '0;
            bit_q     <= '0;
            addr_q    <= '0;
            reg_q     <= '0;
            two_q     <= 1'b0;
            sda_q     <= 1'b1;
            rx_q      <= '0;
            ack_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            addr_q    <= addr_d;
            reg_q     <= reg_d;
            two_q     <= two_d;
            sda_q     <= sda_d;
            rx_q      <= rx_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        SDAO        = 1'b1;
        SCLO        = 1'b1;
        END_OK      = (state_q == IDLE) || (state_q == ARM) || (state_q == DONE);
        RDATA_VALID = (state_q == DONE) && !ack_err_q;
        ACK_ERR     = ack_err_q;
        RDATA       = rdata_q;
        ST          = {4'd0, state_q};
        case (state_q)
            S1:   begin SDAO = 1'b0;   SCLO = 1'b1; end
            S2:   begin SDAO = 1'b0;   SCLO = 1'b0; end
            BSET: begin SDAO = tx_bit; SCLO = 1'b0; end
            BHI:  begin SDAO = tx_bit; SCLO = 1'b1; end
            BLO:  begin SDAO = tx_bit; SCLO = 1'b0; end
            RS1:  begin SDAO = 1'b1;   SCLO = 1'b0; end
            RS2:  begin SDAO = 1'b1;   SCLO = 1'b1; end
            RS3:  begin SDAO = 1'b0;   SCLO = 1'b1; end
            P1:   begin SDAO = 1'b0;   SCLO = 1'b0; end
            P2:   begin SDAO = 1'b0;   SCLO = 1'b1; end
            P3:   begin SDAO = 1'b1;   SCLO = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hdmi_i2c_read_rdata.sv
// Bench for hdmi_i2c_read_rdata: protocol-level tick schedule model, a bus
// decoder, and literal expectations for frames, END_OK width and RDATA.
module tb_hdmi_i2c_read_rdata;

    logic        PT_CK = 1'b0;
    logic        RESET, GO, SDAI;
    logic [7:0]  SLAVE_ADDRESS, REG_ADDR;
    logic [1:0]  BYTE_NUM;
    logic        SDAO, SCLO, END_OK, ACK_ERR, RDATA_VALID;
    logic [15:0] RDATA;
    logic [7:0]  ST;

    hdmi_i2c_read_rdata dut (
        .PT_CK(PT_CK), .RESET(RESET), .GO(GO), .SLAVE_ADDRESS(SLAVE_ADDRESS),
        .REG_ADDR(REG_ADDR), .BYTE_NUM(BYTE_NUM), .SDAI(SDAI), .SDAO(SDAO),
        .SCLO(SCLO), .END_OK(END_OK), .ACK_ERR(ACK_ERR), .RDATA(RDATA),
        .RDATA_VALID(RDATA_VALID), .ST(ST)
    );

    always #5 PT_CK = ~PT_CK;

    typedef struct {
        bit          sda;
        bit          scl;
        bit          sdai;
        bit          endok;
        bit          rvalid;
        bit          aerr;
        logic [15:0] rdata;
    } tick_t;

    tick_t       bq[$];
    tick_t       expq[$];
    logic [8:0]  mon_q[$];
    logic [8:0]  exp_fr[$];
    int          total = 0, bad = 0;
    int          lowcnt = 0, last_low = 0, rvcnt = 0;
    bit          m_eo, m_err;
    logic [15:0] m_rd, rdata_model = 16'h0000;
    logic        mp_scl = 1'b1, mp_ln = 1'b1, ln;
    int          mbc = 0;
    logic [8:0]  msh = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input bit sda, input bit scl, input bit sd, input bit rv);
        tick_t t;
        t.sda = sda; t.scl = scl; t.sdai = sd; t.endok = m_eo;
        t.rvalid = rv; t.aerr = m_err; t.rdata = m_rd;
        bq.push_back(t);
    endtask

    // One 9-bit slot sequence: master bits b then m9, slave drives sb then s9.
    task automatic frame(input logic [7:0] b, input bit m9, input bit s9, input logic [7:0] sb);
        bit bm, bs;
        for (int i = 0; i < 9; i++) begin
            bm = (i < 8) ? b[7-i]  : m9;
            bs = (i < 8) ? sb[7-i] : s9;
            add(bm, 1'b0, bs, 1'b0);
            add(bm, 1'b1, bs, 1'b0);
            add(bm, 1'b0, bs, 1'b0);
        end
    endtask

    task automatic build(input logic [7:0] a, input logic [7:0] r, input logic [1:0] bn,
                         input logic [7:0] d1, input logic [7:0] d2, input int nk);
        int n;
        bit ok;
        n = (bn >= 2'd2) ? 2 : 1;
        bq.delete();
        m_eo = 1'b0; m_err = 1'b0; m_rd = rdata_model; ok = 1'b1;
        add(1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0);
        frame({a[7:1], 1'b0}, 1'b1, nk == 1, 8'hFF);
        if (nk == 1) ok = 1'b0;
        if (ok) begin
            frame(r, 1'b1, nk == 2, 8'hFF);
            if (nk == 2) ok = 1'b0;
        end
        if (ok) begin
            add(1'b1, 1'b0, 1'b1, 1'b0);
            add(1'b1, 1'b1, 1'b1, 1'b0);
            add(1'b0, 1'b1, 1'b1, 1'b0);
            frame({a[7:1], 1'b1}, 1'b1, nk == 3, 8'hFF);
            if (nk == 3) ok = 1'b0;
        end
        if (ok) begin
            frame(8'hFF, n == 1, 1'b1, d1);
            if (n == 2) frame(8'hFF, 1'b1, 1'b1, d2);
        end
        if (!ok) m_err = 1'b1;
        add(1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0);
        m_eo = 1'b1;
        if (ok) m_rd = (n == 2) ? {d1, d2} : {8'h00, d1};
        add(1'b1, 1'b1, 1'b1, ok);
        add(1'b1, 1'b1, 1'b1, 1'b0);
        rdata_model = m_rd;
    endtask

    // Returns #1 after the launch edge, with inputs already scrambled.
    task automatic launch(input logic [7:0] a, input logic [7:0] r, input logic [1:0] bn, input bit hold);
        @(negedge PT_CK);
        GO = 1'b1; SLAVE_ADDRESS = a; REG_ADDR = r; BYTE_NUM = bn;
        @(negedge PT_CK);
        GO = 1'b0;
        @(posedge PT_CK);
        #1;
        SLAVE_ADDRESS = ~a; REG_ADDR = ~r; BYTE_NUM = ~bn; GO = hold;
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] r, input logic [1:0] bn,
                           input logic [7:0] d1, input logic [7:0] d2, input int nk,
                           input bit hold, input int exp_low, input logic [15:0] exp_rd);
        int nlow;
        build(a, r, bn, d1, d2, nk);
        nlow = 0;
        foreach (bq[i]) if (!bq[i].endok) nlow++;
        chk("model_low_ticks", nlow, exp_low);
        mon_q.delete();
        rvcnt = 0;
        launch(a, r, bn, hold);
        expq = bq;
        #1 SDAI = bq[0].sdai;
        for (int t = 1; t < bq.size(); t++) begin
            @(posedge PT_CK);
            #2 SDAI = bq[t].sdai;
        end
        @(posedge PT_CK);
        #1;
        chk("sched_drained", expq.size(), 0);
        chk("endok_low_ticks", last_low, exp_low);
        chk("rvalid_pulses", rvcnt, (nk == 0) ? 1 : 0);
        chk("ack_err_after", ACK_ERR, (nk != 0) ? 1 : 0);
        chk("rdata_after", RDATA, exp_rd);
        chk("frame_count", mon_q.size(), exp_fr.size());
        for (int i = 0; i < exp_fr.size(); i++)
            if (i < mon_q.size()) chk("bus_frame", mon_q[i], exp_fr[i]);
    endtask

    initial begin
        RESET = 1'b1; GO = 1'b0; SDAI = 1'b1;
        SLAVE_ADDRESS = 8'h00; REG_ADDR = 8'h00; BYTE_NUM = 2'd0;

        fork
            forever begin
                @(negedge PT_CK);
                if (expq.size() > 0) begin
                    tick_t e;
                    e = expq.pop_front();
                    chk("tick_sdao",   SDAO,        e.sda);
                    chk("tick_sclo",   SCLO,        e.scl);
                    chk("tick_end_ok", END_OK,      e.endok);
                    chk("tick_rvalid", RDATA_VALID, e.rvalid);
                    chk("tick_ackerr", ACK_ERR,     e.aerr);
                    chk("tick_rdata",  RDATA,       e.rdata);
                end
            end
            forever begin
                @(negedge PT_CK);
                ln = SDAO & SDAI;
                if (SCLO === 1'b1 && mp_scl === 1'b1 && mp_ln !== ln) mbc = 0;
                else if (SCLO === 1'b1 && mp_scl === 1'b0) begin
                    msh = {msh[7:0], ln};
                    mbc++;
                    if (mbc == 9) begin
                        mon_q.push_back(msh);
                        mbc = 0;
                    end
                end
                mp_scl = SCLO; mp_ln = ln;
                if (END_OK === 1'b0) lowcnt++;
                else if (lowcnt != 0) begin
                    last_low = lowcnt;
                    lowcnt = 0;
                end
                if (RDATA_VALID === 1'b1) rvcnt++;
            end
        join_none

        repeat (3) @(posedge PT_CK);
        @(negedge PT_CK);
        chk("rst_sdao", SDAO, 1);
        chk("rst_sclo", SCLO, 1);
        chk("rst_end_ok", END_OK, 1);
        chk("rst_ack_err", ACK_ERR, 0);
        chk("rst_rdata", RDATA, 16'h0000);
        chk("rst_rvalid", RDATA_VALID, 0);
        chk("rst_st", ST, 8'd0);
        RESET = 1'b0;

        exp_fr = '{{8'h72, 1'b0}, {8'h41, 1'b0}, {8'h73, 1'b0}, {8'hA5, 1'b1}};
        run_txn(8'h72, 8'h41, 2'd1, 8'hA5, 8'h00, 0, 1'b0, 116, 16'h00A5);

        exp_fr = '{{8'h72, 1'b0}, {8'h41, 1'b0}, {8'h73, 1'b0}, {8'h12, 1'b0}, {8'h34, 1'b1}};
        run_txn(8'h72, 8'h41, 2'd2, 8'h12, 8'h34, 0, 1'b0, 143, 16'h1234);

        exp_fr = '{{8'h72, 1'b1}};
        run_txn(8'h72, 8'h41, 2'd1, 8'h99, 8'h00, 1, 1'b0, 32, 16'h1234);

        exp_fr = '{{8'h72, 1'b0}, {8'h41, 1'b0}, {8'h73, 1'b1}};
        run_txn(8'h72, 8'h41, 2'd2, 8'h99, 8'h98, 3, 1'b0, 89, 16'h1234);

        exp_fr = '{{8'h72, 1'b0}, {8'h07, 1'b0}, {8'h73, 1'b0}, {8'h5A, 1'b1}};
        run_txn(8'h73, 8'h07, 2'd0, 8'h5A, 8'h00, 0, 1'b0, 116, 16'h005A);

        exp_fr = '{{8'h72, 1'b0}, {8'h10, 1'b0}, {8'h73, 1'b0}, {8'hC3, 1'b0}, {8'h3C, 1'b1}};
        run_txn(8'h72, 8'h10, 2'd3, 8'hC3, 8'h3C, 0, 1'b1, 143, 16'hC33C);

        // GO was held high through DONE: nothing may start until it drops.
        repeat (20) begin
            @(negedge PT_CK);
            chk("hold_end_ok", END_OK, 1);
            chk("hold_sclo", SCLO, 1);
        end

        build(8'h72, 8'h41, 2'd1, 8'hEE, 8'h00, 0);
        mon_q.delete();
        rvcnt = 0;
        launch(8'h72, 8'h41, 2'd1, 1'b0);
        expq = bq;
        #1 SDAI = bq[0].sdai;
        for (int t = 1; t < 95; t++) begin
            @(posedge PT_CK);
            #2 SDAI = bq[t].sdai;
        end
        expq.delete();
        RESET = 1'b1;
        @(posedge PT_CK);
        @(negedge PT_CK);
        chk("midrst_sdao", SDAO, 1);
        chk("midrst_sclo", SCLO, 1);
        chk("midrst_end_ok", END_OK, 1);
        chk("midrst_st", ST, 8'd0);
        chk("midrst_rvalid", RDATA_VALID, 0);
        chk("midrst_rdata", RDATA, 16'h0000);
        RESET = 1'b0;
        SDAI = 1'b1;
        rdata_model = 16'h0000;
        repeat (10) @(negedge PT_CK);
        chk("midrst_no_pulse", rvcnt, 0);
        chk("midrst_idle_end_ok", END_OK, 1);

        exp_fr = '{{8'h72, 1'b0}, {8'h41, 1'b0}, {8'h73, 1'b0}, {8'hBE, 1'b0}, {8'hEF, 1'b1}};
        run_txn(8'h72, 8'h41, 2'd2, 8'hBE, 8'hEF, 0, 1'b0, 143, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
